in_order_dispatcher: RTL and testbench
======================================

# in_order_dispatcher

Round-robin dispatcher that sits upstream of a bank of `n_inputs` variable-latency workers whose results are recombined by `put_in_order`. It takes one upstream valid/ready stream and issues each item to the next worker slot in strict cyclic order (slot 0, 1, … `n_inputs`−1, 0, …). It tracks one outstanding request per slot and stalls upstream while the next slot in order is still busy, so the downstream reorder buffer never sees two in-flight items on one slot.

## Interface
Parameters:
- `width`, 8, data width of one item
- `n_inputs`, 10, number of worker slots (≥2)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `up_vld`  in  1  upstream item valid
- `up_rdy`  out  1  dispatcher can accept an item this cycle
- `up_data`  in  `width`  upstream item
- `req_vlds`  out  `n_inputs`  one-hot issue strobe per slot, registered
- `req_data`  out  `n_inputs`×`width`  per-slot issued item, registered, held until next issue to that slot
- `ret_vlds`  in  `n_inputs`  per-slot completion pulse from workers
- `busy`  out  `n_inputs`  per-slot outstanding flag
- `n_outstanding`  out  `$clog2(n_inputs+1)`  popcount of `busy`
- `issue_ptr`  out  `$clog2(n_inputs)`  slot receiving the next accepted item
- `err`  out  1  sticky protocol error

## Operation
- State: `issue_ptr`, `busy[n_inputs]`, `n_outstanding`, `err`, `req_vlds`, `req_data`.
- `up_rdy = ~busy[issue_ptr]`: combinational from registered state only, with no bypass from `ret_vlds`.
- Accept when `up_vld && up_rdy`:
  - next edge sets `busy[issue_ptr]`
  - loads `req_data[issue_ptr] <= up_data`
  - pulses `req_vlds` one-hot at that slot for exactly one cycle
  - advances `issue_ptr`, wrapping `n_inputs`−1 → 0
- No accept: `req_vlds` = 0; `issue_ptr` and `req_data` hold.
- Return: `ret_vlds[i]` clears `busy[i]` next edge. Multiple returns in one cycle are legal.
- Simultaneous accept on slot j and return on slot k≠j: both take effect; `n_outstanding` changes by +1−1 = 0.
- Return on slot `issue_ptr` in the same cycle `up_rdy`=0: slot frees next edge; `up_rdy` rises the following cycle.
- Return on a slot with `busy`=0: `err` sets and stays set until reset; `busy` is unchanged.
- `n_outstanding` is a registered counter updated as +accept − (number of valid returns). It must always equal the popcount of `busy`.
- All slots busy ⇒ `up_rdy`=0 regardless of `up_vld`.

## Timing
- Reset (async assert, sync release by the system): `issue_ptr`=0, `busy`=0, `n_outstanding`=0, `req_vlds`=0, `req_data`=0, `err`=0; `up_rdy`=1.
- Reset mid-operation: all in-flight state is discarded. Returns arriving after reset on non-busy slots set `err`; the system must drain workers before releasing reset.
- Latency: accept at edge N ⇒ `req_vlds` high during cycle N+1.
- Throughput: one item/cycle while the next slot is free.
- Return-to-ready on a blocked slot: 1 cycle (return at edge N ⇒ `up_rdy`=1 after edge N).
- `up_data` is sampled only on accept; `up_vld` may drop without a handshake (no stability requirement on the upstream side).

## Structure
- Package `dispatch_pkg`: default `width`/`n_inputs` constants and a `wrap_inc(ptr, max)` function; the ptr and count widths are derived from these.
- Sub-module `rr_slot_ptr`: wrap-around pointer with `clk`, `rst_n`, `adv` input and `ptr` output. `issue_ptr` comes from it.
- Popcount is not needed in RTL (counter); the bench checks `n_outstanding` against popcount of `busy`.

## Test plan
- Reset, then `up_vld`=1 for 10 cycles with data 0x00…0x09 and no returns ⇒ `req_vlds` one-hot slots 0…9 on consecutive cycles; `busy`=0x3FF; `n_outstanding`=10; `up_rdy`=0; `issue_ptr`=0.
- From full, `ret_vlds`=0x004 (slot 2) ⇒ `up_rdy` stays 0 (`issue_ptr`=0 still busy); then `ret_vlds`=0x001 ⇒ `up_rdy`=1 next cycle; item 0xAA issues to slot 0.
- Steady stream with returns exactly 3 cycles after each issue ⇒ `up_rdy` never drops; wraps 9→0 verified; `req_data` matches input order.
- Accept to slot 4 and return on slot 7 in the same cycle ⇒ `n_outstanding` unchanged; `busy[4]`=1, `busy[7]`=0.
- `ret_vlds`=0x100 while `busy[8]`=0 ⇒ `err`=1 next cycle, still 1 after 20 idle cycles; `busy` unchanged.
- Assert `rst_n`=0 asynchronously mid-stream with 5 outstanding ⇒ all outputs 0 immediately (before next edge); `up_rdy`=1.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared constants and helpers for the in-order dispatcher slice.
// Pointer and count widths are derived from the slot count in the modules that use them.
package dispatch_pkg;

  localparam int default_width    = 8;
  localparam int default_n_inputs = 10;

  // Advance a slot pointer, returning to 0 after max.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] max);
    return (ptr >= max) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/in_order_dispatcher_if.sv
// Upstream stream, per-slot issue/return lines and status for the dispatcher.
interface in_order_dispatcher_if
  import dispatch_pkg::*;
#(
  parameter int width    = default_width,
  parameter int n_inputs = default_n_inputs
);
  localparam int ptr_w = ptr_width(n_inputs);
  localparam int cnt_w = cnt_width(n_inputs);

  logic                           up_vld;
  logic                           up_rdy;
  logic [width-1:0]               up_data;
  logic [n_inputs-1:0]            req_vlds;
  logic [n_inputs-1:0][width-1:0] req_data;
  logic [n_inputs-1:0]            ret_vlds;
  logic [n_inputs-1:0]            busy;
  logic [cnt_w-1:0]               n_outstanding;
  logic [ptr_w-1:0]               issue_ptr;
  logic                           err;

  modport master (
    output up_vld, up_data, ret_vlds,
    input  up_rdy, req_vlds, req_data, busy, n_outstanding, issue_ptr, err
  );

  modport slave (
    input  up_vld, up_data, ret_vlds,
    output up_rdy, req_vlds, req_data, busy, n_outstanding, issue_ptr, err
  );

endinterface

// File: rtl/rr_slot_ptr.sv
// Wrap-around slot pointer: steps 0 .. n_slots-1 and back to 0 on each adv.
module rr_slot_ptr
  import dispatch_pkg::*;
#(
  parameter int n_slots = default_n_inputs,
  localparam int ptr_w  = ptr_width(n_slots)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [ptr_w-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr_w'(wrap_inc(32'(ptr), 32'(n_slots - 1)));
    end
  end

endmodule

// File: rtl/in_order_dispatcher.sv
// Issues upstream items to worker slots in strict cyclic order, one outstanding per slot,
// stalling while the next slot in order is still busy.
module in_order_dispatcher
  import dispatch_pkg::*;
#(
  parameter int width    = default_width,
  parameter int n_inputs = default_n_inputs
) (
  input logic                  clk,
  input logic                  rst_n,
  in_order_dispatcher_if.slave bus
);

  localparam int ptr_w = ptr_width(n_inputs);
  localparam int cnt_w = cnt_width(n_inputs);

  logic [ptr_w-1:0]               ptr;
  logic [n_inputs-1:0]            busy_q;
  logic [n_inputs-1:0]            busy_d;
  logic [n_inputs-1:0]            acc_vec;
  logic [n_inputs-1:0]            ret_ok;
  logic [n_inputs-1:0]            req_vlds_q;
  logic [n_inputs-1:0][width-1:0] req_data_q;
  logic [cnt_w-1:0]               cnt_q;
  logic [cnt_w-1:0]               cnt_d;
  logic [cnt_w-1:0]               ret_cnt;
  logic                           err_q;
  logic                           rdy;
  logic                           accept;
  logic                           ret_bad;

  // Ready looks only at registered busy; a return this cycle frees the slot next cycle.
  assign rdy     = ~busy_q[ptr];
  assign accept  = bus.up_vld & rdy;
  assign ret_ok  = bus.ret_vlds & busy_q;
  assign ret_bad = |(bus.ret_vlds & ~busy_q);

  always_comb begin
    acc_vec = '0;
    ret_cnt = '0;
    for (int i = 0; i < n_inputs; i++) begin
      acc_vec[i] = accept && (int'(ptr) == i);
      ret_cnt    = ret_cnt + cnt_w'(ret_ok[i]);
    end
  end

  // The accepted slot is idle, so a return on it is an error and cannot cancel the set.
  assign busy_d = (busy_q & ~bus.ret_vlds) | acc_vec;
  assign cnt_d  = cnt_q + cnt_w'(accept) - ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      req_vlds_q <= '0;
      req_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      req_vlds_q <= acc_vec;
      err_q      <= err_q | ret_bad;
      for (int i = 0; i < n_inputs; i++) begin
        if (acc_vec[i]) begin
          req_data_q[i] <= bus.up_data;
        end
      end
    end
  end

  rr_slot_ptr #(
    .n_slots(n_inputs)
  ) u_slot_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (accept),
    .ptr  (ptr)
  );

  assign bus.up_rdy        = rdy;
  assign bus.req_vlds      = req_vlds_q;
  assign bus.req_data      = req_data_q;
  assign bus.busy          = busy_q;
  assign bus.n_outstanding = cnt_q;
  assign bus.issue_ptr     = ptr;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_in_order_dispatcher.sv
// Directed scenes plus a randomized phase, checked against a slot-array reference model.
module tb_in_order_dispatcher;

  localparam int N = 10;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  in_order_dispatcher_if #(.width(W), .n_inputs(N)) bus ();

  in_order_dispatcher #(.width(W), .n_inputs(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: which slots hold work, what each slot last received, where the next item goes.
  bit          m_busy [N];
  logic [W-1:0] m_data [N];
  int          m_ptr;
  bit          m_err;
  logic [N-1:0] exp_req;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_busy_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_data[i] = '0;
    end
    m_ptr   = 0;
    m_err   = 1'b0;
    exp_req = '0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.up_vld   = 1'b0;
    bus.up_data  = '0;
    bus.ret_vlds = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_state();
    check_eq("req_vlds", 32'(bus.req_vlds), 32'(exp_req));
    for (int i = 0; i < N; i++) check_eq($sformatf("req_data[%0d]", i), 32'(bus.req_data[i]), 32'(m_data[i]));
    check_eq("busy", 32'(bus.busy), 32'(model_busy_vec()));
    check_eq("n_outstanding", 32'(bus.n_outstanding), 32'(model_count()));
    check_eq("cnt_vs_busy", 32'(bus.n_outstanding), 32'($countones(bus.busy)));
    check_eq("issue_ptr", 32'(bus.issue_ptr), 32'(m_ptr));
    check_eq("err", 32'(bus.err), 32'(m_err));
  endtask

  // One clock: drive at negedge, check ready, advance model, check registered state after the edge.
  task automatic step(input bit vld, input logic [W-1:0] data, input logic [N-1:0] ret);
    bit acc;
    @(negedge clk);
    bus.up_vld   = vld;
    bus.up_data  = data;
    bus.ret_vlds = ret;
    #1;
    check_eq("up_rdy", 32'(bus.up_rdy), 32'(!m_busy[m_ptr]));
    acc     = vld && !m_busy[m_ptr];
    exp_req = '0;
    for (int i = 0; i < N; i++) begin
      if (ret[i]) begin
        if (m_busy[i]) m_busy[i] = 1'b0;
        else           m_err     = 1'b1;
      end
    end
    if (acc) begin
      m_busy[m_ptr]  = 1'b1;
      m_data[m_ptr]  = data;
      exp_req[m_ptr] = 1'b1;
      m_ptr          = (m_ptr + 1) % N;
    end
    @(posedge clk);
    #1;
    bus.up_vld   = 1'b0;
    bus.ret_vlds = '0;
    check_state();
  endtask

  initial begin
    logic [N-1:0] ret;
    bus.up_vld   = 1'b0;
    bus.up_data  = '0;
    bus.ret_vlds = '0;
    model_reset();

    // Reset values while held in reset.
    #12;
    check_eq("rst_up_rdy", 32'(bus.up_rdy), 32'd1);
    check_state();
    do_reset();

    // Fill every slot in order.
    for (int i = 0; i < N; i++) begin
      step(1'b1, W'(i), '0);
      check_eq("fill_onehot", 32'(bus.req_vlds), 32'(1) << i);
    end
    check_eq("full_busy", 32'(bus.busy), 32'h3FF);
    check_eq("full_cnt", 32'(bus.n_outstanding), 32'd10);
    check_eq("full_rdy", 32'(bus.up_rdy), 32'd0);
    check_eq("full_ptr", 32'(bus.issue_ptr), 32'd0);

    // Free slot 2 (not next in order), then slot 0.
    step(1'b0, '0, 10'h004);
    check_eq("blk_rdy", 32'(bus.up_rdy), 32'd0);
    step(1'b1, 8'hAA, 10'h001);
    check_eq("unblk_rdy", 32'(bus.up_rdy), 32'd1);
    step(1'b1, 8'hAA, '0);
    check_eq("aa_vld", 32'(bus.req_vlds), 32'h001);
    check_eq("aa_data", 32'(bus.req_data[0]), 32'hAA);

    // Steady stream, each slot returned three cycles after its issue.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      ret = '0;
      if (c >= 3) ret[(c - 3) % N] = 1'b1;
      step(1'b1, W'($urandom), ret);
      check_eq("stream_rdy", 32'(bus.up_rdy), 32'd1);
    end

    // Accept on slot 4 while slot 7 returns.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'($urandom), '0);
    step(1'b0, '0, 10'h03F);
    for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), '0);
    check_eq("pre_ptr4", 32'(bus.issue_ptr), 32'd4);
    step(1'b1, 8'h44, 10'h080);
    check_eq("same_cyc_cnt", 32'(bus.n_outstanding), 32'd8);
    check_eq("same_cyc_b4", 32'(bus.busy[4]), 32'd1);
    check_eq("same_cyc_b7", 32'(bus.busy[7]), 32'd0);

    // Return on an idle slot raises a sticky error.
    step(1'b0, '0, 10'h100);
    check_eq("pre_err", 32'(bus.err), 32'd0);
    step(1'b0, '0, 10'h100);
    check_eq("err_set", 32'(bus.err), 32'd1);
    repeat (20) step(1'b0, '0, '0);
    check_eq("err_sticky", 32'(bus.err), 32'd1);
    check_eq("err_busy", 32'(bus.busy), 32'h25F);

    // Asynchronous reset mid-stream with five outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h10 + i), '0);
    check_eq("pre_arst_cnt", 32'(bus.n_outstanding), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_rdy", 32'(bus.up_rdy), 32'd1);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with legal returns only.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ret = '0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && ($urandom_range(0, 2) == 0)) ret[i] = 1'b1;
      end
      step($urandom_range(0, 3) != 0, W'($urandom), ret);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
